booth_seq_multiplier: RTL and testbench

Iterative radix-4 Booth controller and accumulator for the FMAC mantissa multiplier. It sits directly upstream and downstream of the partial-product selector. It Booth-encodes a latched unsigned multiplier one digit per cycle and drives the selector's 3-bit action code and the multiplicand. It then sign-extends, shifts and accumulates the 10-bit partial product the selector returns in the same cycle. After all digits it presents the unsigned 16-bit product with a one-cycle done pulse.

---
 rtl/booth_seq_multiplier.sv | 132 +++++++++++++
 tb/tb_booth_seq_multiplier.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Radix-4 Booth sequencer and accumulator for the FMAC mantissa multiplier.
// Each RUN cycle encodes one Booth digit of the latched multiplier into the
// selector action code. The same cycle it sign-extends, shifts and
// accumulates the partial product that the selector returns.
//
// Handshake: start is a request that is only sampled while busy=0 (IDLE);
// an accepted start latches both operands. done is a one-cycle valid
// strobe qualifying product, which stays held until the next completion
// or reset. There is no back-pressure on the result side.
module booth_seq_multiplier #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplier,
    input  logic [N-1:0]     multiplicand,
    output logic [2:0]       action,
    output logic [N-1:0]     mcand_out,
    input  logic [N+1:0]     partial_product,
    output logic [2*N-1:0]   product,
    output logic             busy,
    output logic             done
);

    localparam int D  = N / 2 + 1;   // number of Booth digits
    localparam int PW = N + 2;       // partial-product width
    localparam int AW = 2 * N + 2;   // accumulator width
    localparam int CW = $clog2(D + 1);
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [N+2:0]    p_q, p_d;          // {2'b00, multiplier, 1'b0}
    logic [N-1:0]    mcand_q, mcand_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            done_q, done_d;

    logic [CW:0]     shamt;
    logic [N+2:0]    p_shifted;
    logic [2:0]      triplet;
    logic [2:0]      booth_code;
    logic [AW-1:0]   term;
    logic [AW-1:0]   acc_sum;

    // Booth-encode the current digit triplet and form the shifted, sign-extended term
    always_comb begin
        shamt      = {count_q, 1'b0};
        p_shifted  = p_q >> shamt;
        triplet    = p_shifted[2:0];
        booth_code = 3'b000;
        unique case (triplet)
            3'b001, 3'b010: booth_code = 3'b100;   // +M
            3'b011:         booth_code = 3'b010;   // +2M
            3'b100:         booth_code = 3'b011;   // -2M
            3'b101, 3'b110: booth_code = 3'b101;   // -M
            default:        booth_code = 3'b000;   // 000 and 111 add nothing
        endcase
        term    = {{(AW - PW){partial_product[PW-1]}}, partial_product} << shamt;
        acc_sum = acc_q + term;
    end

    // Next-state logic: operand capture, digit stepping, completion
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        p_d       = p_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = {2'b00, multiplier, 1'b0};
                    mcand_d = multiplicand;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_sum;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    // Intermediate acc may be negative; the final sum is not
                    product_d = acc_sum[2*N-1:0];
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            p_q       <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            p_q       <= p_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Outputs derived from state and registers
    always_comb begin
        busy      = (state_q == RUN);
        action    = (state_q == RUN) ? booth_code : 3'b000;
        mcand_out = mcand_q;
        product   = product_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: models the partial-product selector,
// keeps a transaction-level reference (product = a*b, Booth digit per step)
// and compares every cycle, plus literal scenario checks.
module tb_booth_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplier;
    logic [7:0]  multiplicand;
    logic [2:0]  action;
    logic [7:0]  mcand_out;
    logic [9:0]  partial_product;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    booth_seq_multiplier #(.N(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .multiplier      (multiplier),
        .multiplicand    (multiplicand),
        .action          (action),
        .mcand_out       (mcand_out),
        .partial_product (partial_product),
        .product         (product),
        .busy            (busy),
        .done            (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // selector model: value the action code asks for
    always_comb begin
        case (action)
            3'b100:  partial_product = {2'b00, mcand_out};
            3'b010:  partial_product = {1'b0, mcand_out, 1'b0};
            3'b101:  partial_product = -{2'b00, mcand_out};
            3'b011:  partial_product = -{1'b0, mcand_out, 1'b0};
            default: partial_product = 10'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Booth digit k of b: -2*b[2k+1] + b[2k] + b[2k-1], mapped to its code
    function automatic logic [2:0] booth_code(input logic [7:0] b, input int k);
        int v;
        int d;
        v = int'(b) << 1;
        d = -2 * ((v >> (2 * k + 2)) & 1) + ((v >> (2 * k + 1)) & 1) + ((v >> (2 * k)) & 1);
        case (d)
            1:       return 3'b100;
            2:       return 3'b010;
            -1:      return 3'b101;
            -2:      return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // reference model: transaction-level behaviour
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_cnt  = 0;
    logic [7:0]  m_mb   = 8'd0;
    logic [7:0]  m_mc   = 8'd0;
    logic [15:0] m_prod = 16'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_mc = 8'd0; m_prod = 16'd0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (m_cnt == 4) begin
                    m_busy = 0;
                    m_done = 1;
                    m_prod = m_mc * m_mb;
                end else begin
                    m_cnt++;
                end
            end else if (start) begin
                m_busy = 1;
                m_cnt  = 0;
                m_mb   = multiplier;
                m_mc   = multiplicand;
            end
        end
    end

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_product", 32'(product), 32'(m_prod));
            check("cyc_mcand_out", 32'(mcand_out), 32'(m_mc));
            check("cyc_action", 32'(action), m_busy ? 32'(booth_code(m_mb, m_cnt)) : 32'd0);
        end
    end

    // driver: one operation with literal expectations
    task automatic run_literal(input string nm, input logic [7:0] mc, input logic [7:0] mb,
                               input logic [14:0] exp_acts, input logic [15:0] exp_prod,
                               input bit hold);
        logic [14:0] acts;
        acts = '0;
        multiplicand = mc;
        multiplier   = mb;
        start        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            check({nm, "_busy"}, 32'(busy), 32'd1);
            check({nm, "_done_low"}, 32'(done), 32'd0);
            acts = {acts[11:0], action};
        end
        @(negedge clk);
        check({nm, "_actions"}, 32'(acts), 32'(exp_acts));
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_busy_off"}, 32'(busy), 32'd0);
        check({nm, "_product"}, 32'(product), 32'(exp_prod));
        if (!hold) begin
            @(negedge clk);
            check({nm, "_done_pulse"}, 32'(done), 32'd0);
            check({nm, "_product_held"}, 32'(product), 32'(exp_prod));
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        multiplier = 8'd0;
        multiplicand = 8'd0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        check("reset_product", 32'(product), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_action", 32'(action), 32'd0);
        check("reset_mcand", 32'(mcand_out), 32'd0);
        rst = 1'b0;

        run_literal("t1_13x11", 8'd13, 8'd11, 15'b101_101_100_000_000, 16'd143, 0);
        run_literal("t2_255x255", 8'd255, 8'd255, 15'b101_000_000_000_100, 16'hFE01, 0);
        run_literal("t3_3xAA", 8'd3, 8'hAA, 15'b011_101_101_101_100, 16'd510, 0);
        run_literal("t4_0xC8", 8'd0, 8'hC8, 15'b000_011_100_101_100, 16'd0, 0);
        run_literal("t4_200x0", 8'd200, 8'd0, 15'b000_000_000_000_000, 16'd0, 0);
        run_literal("t5_13x11_hold", 8'd13, 8'd11, 15'b101_101_100_000_000, 16'd143, 1);
        run_literal("t5_7x9", 8'd7, 8'd9, 15'b100_011_100_000_000, 16'd63, 0);

        // reset in the third RUN cycle of 200x100
        multiplicand = 8'd200;
        multiplier   = 8'd100;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_product", 32'(product), 32'd0);
        check("t6_action", 32'(action), 32'd0);
        run_literal("t6_10x10", 8'd10, 8'd10, 15'b011_101_100_000_000, 16'd100, 0);

        // randomized traffic checked by the per-cycle scoreboard
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                multiplier = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            else
                multiplier = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                multiplicand = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            else
                multiplicand = 8'($urandom);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
